// File: rtl/stream_lane_packer16.sv
// Lane compactor: packs the valid lanes of sparse 16-lane beats into dense
// 16-lane output beats, emitting one partial beat at each packet tail.
module stream_lane_packer16 #(
  parameter int LANE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [16*LANE_W-1:0] s_data,
  input  logic [15:0]          s_mask,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [16*LANE_W-1:0] m_data,
  output logic [15:0]          m_keep,
  output logic                 m_last
);

  localparam int DW = 16 * LANE_W;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_r;
  logic [2*DW-1:0] buf_r;
  logic [4:0]      f_r;
  logic            m_valid_r;
  logic [DW-1:0]   m_data_r;
  logic [15:0]     m_keep_r;
  logic            m_last_r;

  logic [2*DW-1:0] merged_s;
  logic [2*DW-1:0] shifted_s;
  logic [5:0]      t_s;
  logic            slot_free_s;
  logic            accept_s;

  // Thermometer keep code for n valid lanes, n = 0..16.
  function automatic logic [15:0] thermo(input logic [4:0] n);
    logic [16:0] v;
    v = (17'd1 << n) - 17'd1;
    return v[15:0];
  endfunction

  // Zero every lane whose keep bit is clear.
  function automatic logic [DW-1:0] keep_lanes(input logic [DW-1:0] d, input logic [15:0] k);
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i*LANE_W +: LANE_W] = k[i] ? d[i*LANE_W +: LANE_W] : {LANE_W{1'b0}};
    end
    return r;
  endfunction

  // Scatter valid source lanes to buffer position f + prefix_popcount - 1.
  always_comb begin
    merged_s = buf_r;
    t_s      = {1'b0, f_r};
    for (int i = 0; i < 16; i++) begin
      if (s_mask[i]) begin
        merged_s[t_s*LANE_W +: LANE_W] = s_data[i*LANE_W +: LANE_W];
        t_s = t_s + 6'd1;
      end else begin
        t_s = t_s;
      end
    end
  end

  assign shifted_s   = {{DW{1'b0}}, merged_s[2*DW-1:DW]};
  assign slot_free_s = !m_valid_r || m_ready;
  assign s_ready     = (state_r == RUN) && slot_free_s;
  assign accept_s    = s_valid && s_ready;

  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_keep  = m_keep_r;
  assign m_last  = m_last_r;

  // Buffer, fill count, state and output slot update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RUN;
      buf_r     <= {(2*DW){1'b0}};
      f_r       <= 5'd0;
      m_valid_r <= 1'b0;
      m_data_r  <= {DW{1'b0}};
      m_keep_r  <= 16'h0000;
      m_last_r  <= 1'b0;
    end else begin
      if (m_valid_r && m_ready) begin
        m_valid_r <= 1'b0;
      end
      case (state_r)
        RUN: begin
          if (accept_s) begin
            if (t_s < 6'd16) begin
              if (s_last) begin
                m_valid_r <= 1'b1;
                m_data_r  <= keep_lanes(merged_s[DW-1:0], thermo(t_s[4:0]));
                m_keep_r  <= thermo(t_s[4:0]);
                m_last_r  <= 1'b1;
                f_r       <= 5'd0;
                buf_r     <= {(2*DW){1'b0}};
              end else begin
                f_r   <= t_s[4:0];
                buf_r <= merged_s;
              end
            end else begin
              m_valid_r <= 1'b1;
              m_data_r  <= merged_s[DW-1:0];
              m_keep_r  <= 16'hFFFF;
              m_last_r  <= s_last && (t_s == 6'd16);
              if (s_last && (t_s == 6'd16)) begin
                f_r   <= 5'd0;
                buf_r <= {(2*DW){1'b0}};
              end else begin
                // Leftover lanes of an over-full tail go out in a FLUSH beat.
                f_r     <= {1'b0, t_s[3:0]};
                buf_r   <= shifted_s;
                state_r <= s_last ? FLUSH : RUN;
              end
            end
          end
        end
        FLUSH: begin
          if (slot_free_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= keep_lanes(buf_r[DW-1:0], thermo(f_r));
            m_keep_r  <= thermo(f_r);
            m_last_r  <= 1'b1;
            f_r       <= 5'd0;
            buf_r     <= {(2*DW){1'b0}};
            state_r   <= RUN;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_lane_packer16.sv
// Randomized and directed bench for stream_lane_packer16 against a lane-queue
// reference model.
module tb_stream_lane_packer16;

  localparam int LANE_W = 8;
  localparam int DW     = 16 * LANE_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic [15:0]   s_mask;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic [15:0]   m_keep;

  int checks   = 0;
  int failures = 0;
  int ready_mode = 1;

  logic [7:0]    res_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [15:0]   exp_keep_q[$];
  logic          exp_last_q[$];

  always #5 clk = ~clk;

  stream_lane_packer16 #(.LANE_W(LANE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mask(s_mask), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    case ($urandom_range(0, 3))
      0: m = 16'h0000;
      1: m = 16'hFFFF;
      default: m = 16'($urandom);
    endcase
    return m;
  endfunction

  function automatic logic [DW-1:0] ramp(input logic [7:0] base);
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  // Reference model: pop n lanes off the residual queue as one output beat.
  function automatic void emit(input int n, input logic last);
    logic [DW-1:0] d;
    logic [15:0]   k;
    d = '0;
    k = '0;
    for (int i = 0; i < n; i++) begin
      d[i*8 +: 8] = res_q.pop_front();
      k[i] = 1'b1;
    end
    exp_data_q.push_back(d);
    exp_keep_q.push_back(k);
    exp_last_q.push_back(last);
  endfunction

  function automatic void model_accept(input logic [15:0] mask, input logic [DW-1:0] data, input logic last);
    for (int i = 0; i < 16; i++)
      if (mask[i]) res_q.push_back(data[i*8 +: 8]);
    if (!last) begin
      if (res_q.size() >= 16) emit(16, 1'b0);
    end else begin
      if (res_q.size() > 16) emit(16, 1'b0);
      emit(res_q.size(), 1'b1);
    end
  endfunction

  // m_ready driver, steered by ready_mode (0 stall, 1 always, 2 random).
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: m_ready = 1'b0;
        1: m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: scoreboard output beats, hold stability, feed accepted beats to the model.
  initial begin
    logic          prev_hold;
    logic [DW-1:0] prev_data;
    logic [15:0]   prev_keep;
    logic          prev_last;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_keep = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        res_q.delete();
        exp_data_q.delete();
        exp_keep_q.delete();
        exp_last_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check_eq("hold_valid", DW'(m_valid), DW'(1'b1));
          check_eq("hold_data", m_data, prev_data);
          check_eq("hold_keep", DW'(m_keep), DW'(prev_keep));
          check_eq("hold_last", DW'(m_last), DW'(prev_last));
        end
        if (m_valid && m_ready) begin
          if (exp_data_q.size() == 0) begin
            check_eq("beat_expected", DW'(exp_data_q.size() != 0), DW'(1'b1));
          end else begin
            check_eq("out_data", m_data, exp_data_q.pop_front());
            check_eq("out_keep", DW'(m_keep), DW'(exp_keep_q.pop_front()));
            check_eq("out_last", DW'(m_last), DW'(exp_last_q.pop_front()));
          end
        end
        if (s_valid && s_ready) model_accept(s_mask, s_data, s_last);
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
        prev_keep = m_keep;
        prev_last = m_last;
      end
    end
  end

  task automatic drive(input logic [15:0] mask, input logic [DW-1:0] data, input logic last);
    s_valid = 1'b1;
    s_mask  = mask;
    s_data  = data;
    s_last  = last;
  endtask

  task automatic send_beat(input logic [15:0] mask, input logic [DW-1:0] data, input logic last);
    logic ok;
    @(posedge clk);
    #1;
    drive(mask, data, last);
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
    end
    if (!ok) check_eq("send_timeout", DW'(s_ready), DW'(1'b1));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_mask  = 16'h0000;
    s_last  = 1'b0;
    s_data  = rand_data();
  endtask

  task automatic expect_beat(input string tag, input logic [15:0] keep, input logic last);
    check_eq({tag, "_valid"}, DW'(m_valid), DW'(1'b1));
    check_eq({tag, "_keep"}, DW'(m_keep), DW'(keep));
    check_eq({tag, "_last"}, DW'(m_last), DW'(last));
  endtask

  initial begin
    logic [DW-1:0] d, e;
    logic ok;
    rst_n = 1'b0; s_valid = 1'b0; s_mask = '0; s_data = '0; s_last = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_m_valid", DW'(m_valid), DW'(1'b0));
    check_eq("rst_m_keep", DW'(m_keep), DW'(16'h0));
    check_eq("rst_m_last", DW'(m_last), DW'(1'b0));
    check_eq("rst_m_data", m_data, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_s_ready", DW'(s_ready), DW'(1'b1));

    // Dense stream: one full beat per input, one cycle later
    d = rand_data();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; drive(16'hFFFF, d, k == 2);
      @(negedge clk);
      check_eq("dense_ready", DW'(s_ready), DW'(1'b1));
      if (k > 0) begin
        expect_beat("dense", 16'hFFFF, 1'b0);
        check_eq("dense_data", m_data, d);
      end
    end
    idle();
    @(negedge clk);
    expect_beat("dense_tail", 16'hFFFF, 1'b1);
    check_eq("dense_tail_data", m_data, d);

    // Compaction
    send_beat(16'h00FF, ramp(8'h00), 1'b0);
    send_beat(16'hFF00, ramp(8'h10), 1'b0);
    d = rand_data();
    d[7:0] = 8'hAA;
    @(posedge clk); #1; drive(16'h0001, d, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 16; i++) e[i*8 +: 8] = (i < 8) ? 8'(i) : 8'h10 + 8'(i);
    check_eq("comp_ready", DW'(s_ready), DW'(1'b1));
    expect_beat("comp", 16'hFFFF, 1'b0);
    check_eq("comp_data", m_data, e);
    idle();
    @(negedge clk);
    expect_beat("comp_tail", 16'h0001, 1'b1);
    check_eq("comp_tail_data", m_data, DW'(8'hAA));

    // Overflow flush
    send_beat(16'hFFF0, ramp(8'h00), 1'b0);
    send_beat(16'hFFFF, ramp(8'h20), 1'b1);
    idle();
    @(negedge clk);
    for (int i = 0; i < 16; i++) e[i*8 +: 8] = (i < 12) ? 8'(4 + i) : 8'(8'h20 + i - 12);
    expect_beat("ovf_full", 16'hFFFF, 1'b0);
    check_eq("ovf_full_data", m_data, e);
    check_eq("ovf_flush_ready", DW'(s_ready), DW'(1'b0));
    @(negedge clk);
    for (int i = 0; i < 16; i++) e[i*8 +: 8] = (i < 12) ? 8'(8'h24 + i) : 8'h00;
    expect_beat("ovf_res", 16'h0FFF, 1'b1);
    check_eq("ovf_res_data", m_data, e);

    // Empty tail
    send_beat(16'h0000, rand_data(), 1'b1);
    idle();
    @(negedge clk);
    expect_beat("empty", 16'h0000, 1'b1);
    check_eq("empty_data", m_data, '0);

    // Backpressure
    send_beat(16'hFFFF, rand_data(), 1'b0);
    ready_mode = 0;
    @(posedge clk); #1; drive(rand_mask(), rand_data(), 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_s_ready", DW'(s_ready), DW'(1'b0));
      check_eq("bp_m_valid", DW'(m_valid), DW'(1'b1));
    end
    ready_mode = 1;
    ok = 1'b0;
    for (int n = 0; n < 16 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
    end
    if (!ok) check_eq("bp_timeout", DW'(s_ready), DW'(1'b1));
    idle();

    // Reset mid-FLUSH
    send_beat(16'hFFF0, rand_data(), 1'b0);
    send_beat(16'hFFFF, rand_data(), 1'b1);
    ready_mode = 0;
    idle();
    @(negedge clk);
    check_eq("mf_pre_valid", DW'(m_valid), DW'(1'b1));
    check_eq("mf_pre_ready", DW'(s_ready), DW'(1'b0));
    #1; rst_n = 1'b0;
    #1;
    check_eq("mf_rst_valid", DW'(m_valid), DW'(1'b0));
    check_eq("mf_rst_keep", DW'(m_keep), DW'(16'h0));
    check_eq("mf_rst_last", DW'(m_last), DW'(1'b0));
    check_eq("mf_rst_data", m_data, '0);
    @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1; ready_mode = 1;
    @(negedge clk);
    check_eq("mf_s_ready", DW'(s_ready), DW'(1'b1));
    d = rand_data();
    send_beat(16'hFFFF, d, 1'b1);
    idle();
    @(negedge clk);
    expect_beat("mf_after", 16'hFFFF, 1'b1);
    check_eq("mf_after_data", m_data, d);

    // Randomized traffic with random backpressure
    ready_mode = 2;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0) send_beat(rand_mask(), rand_data(), $urandom_range(0, 4) == 0);
      else idle();
    end
    send_beat(rand_mask(), rand_data(), 1'b1);
    idle();
    ready_mode = 1;
    for (int n = 0; n < 100 && exp_data_q.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("drain_empty", DW'(exp_data_q.size()), '0);
    check_eq("residual_empty", DW'(res_q.size()), '0);
    check_eq("drain_m_valid", DW'(m_valid), DW'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
